instruction_encoder: RTL and testbench
======================================

Name: instruction_encoder

Overview:
- Inverse of the instruction decoder: packs opcode, register-address, flag and immediate fields into the 16-bit instruction word the decoder consumes.
- Sits between the test sequencer / program loader and instruction memory or the decoder's `instruct` input.
- Encoded words are buffered in a small first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Counts issued instructions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, log2(DEPTH); pointer width.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- in_valid  input  1  field set on the inputs is valid.
- in_ready  output  1  encoder can accept a field set.
- opcode  input  4  placed at instruct[15:12].
- rDadrs  input  3  placed at instruct[11:9].
- flag  input  1  placed at instruct[8].
- imm_sel  input  1  1 = immediate form, 0 = register form.
- imm  input  8  placed at instruct[7:0] when imm_sel = 1.
- rAadrs  input  3  placed at instruct[7:5] when imm_sel = 0.
- rBadrs  input  3  placed at instruct[4:2] when imm_sel = 0.
- out_valid  output  1  out_instruct holds a valid word.
- out_ready  input  1  consumer accepts out_instruct.
- out_instruct  output  16  encoded instruction at the FIFO head.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.
- issued  output  CNT_W  count of words popped since reset.

Behaviour:
- Packing, combinational on the input side:
  - immediate form: word = {opcode, rDadrs, flag, imm}.
  - register form: word = {opcode, rDadrs, flag, rAadrs, rBadrs, 2'b00}. Bits [1:0] are always 0; imm is ignored.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (level != DEPTH). It depends only on registered state and has no combinational path from out_ready.
- out_valid = (level != 0).
- out_instruct = entry at the read pointer (first-word fall-through). When out_valid = 0, out_instruct is driven to 16'h0000.
- Latency: a push into an empty FIFO appears on out_valid/out_instruct on the cycle after the push edge.
- out_instruct must hold stable while out_valid = 1 and out_ready = 0.
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0.
- level updates per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full with out_ready = 1: in_ready is already 0 that cycle, so only the pop occurs. in_ready rises on the next cycle.
- Empty with in_valid = 1 and out_ready = 1: only the push occurs. No bypass.
- issued increments by 1 on every pop and wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset (reset_n = 0 at a rising edge), including mid-transfer:
  - pointers, level and issued go to 0; out_valid = 0, out_instruct = 0, in_ready = 1 in the following cycle.
  - buffered words are discarded; FIFO storage need not be cleared.
  - a push or pop coincident with the reset edge is ignored.
- Inputs must be ignored while in_valid = 0. X on unused fields (imm in register form, rAadrs/rBadrs in immediate form) must not propagate to out_instruct.

Test Plan:
- Immediate form: opcode=4'h3, rDadrs=5, flag=1, imm_sel=1, imm=8'hA7, out_ready=1 → one cycle later out_valid=1, out_instruct=16'h3BA7; after the pop, issued=1 and level=0.
- Register form: opcode=4'h1, rDadrs=2, flag=0, imm_sel=0, rAadrs=3, rBadrs=6, imm=8'hFF → out_instruct=16'h1478; bits [1:0] are 0 and imm is ignored.
- Fill and backpressure: out_ready=0, push 5 words 16'h0001..0005 using opcode 0, imm form, imm=1..5 → in_ready falls after 4 pushes, level=4, 5th word is not accepted. Then out_ready=1 → words drain in order 0001..0004 with out_instruct stable during stall.
- Simultaneous push/pop at level=2 for 10 cycles → level stays 2, output order matches input order, issued advances by 10, pointer wrap is exercised.
- Reset mid-operation: level=3, assert reset_n=0 for one edge with in_valid=1 and out_ready=1 → next cycle level=0, out_valid=0, out_instruct=0, issued=0, in_ready=1. The coincident push does not appear afterwards.
- Counter wrap: CNT_W=4, pop 17 words → issued reads 0 after the 16th pop and 1 after the 17th.

Source files
------------

// File: rtl/instruction_encoder.sv
// Packs opcode/register/flag/immediate fields into 16-bit instruction words and
// buffers them in a first-word-fall-through FIFO; counts words handed downstream.
module instruction_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [2:0]       rDadrs,
    input  logic             flag,
    input  logic             imm_sel,
    input  logic [7:0]       imm,
    input  logic [2:0]       rAadrs,
    input  logic [2:0]       rBadrs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_instruct,
    output logic [AW:0]      level,
    output logic [CNT_W-1:0] issued
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [15:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [CNT_W-1:0] r_issued;

    logic [15:0]      w_word;
    logic [7:0]       w_low_byte;
    logic             w_push;
    logic             w_pop;

    // Only the selected form's fields reach the word, so X on the unused
    // fields never lands in storage.
    always_comb begin
        w_low_byte = 8'h00;
        if (imm_sel) begin
            w_low_byte = imm;
        end else begin
            w_low_byte = {rAadrs, rBadrs, 2'b00};
        end
        w_word = {opcode, rDadrs, flag, w_low_byte};
    end

    assign in_ready  = (r_level != FULL_LEVEL);
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_instruct = out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign level        = r_level;
    assign issued       = r_issued;

    // Storage is deliberately left out of reset; the pointers define what is live.
    always_ff @(posedge clock) begin
        if (w_push && reset_n) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_issued <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder, using a 4-bit issue
// counter so the wrap is reached within a short run.
module tb_instruction_encoder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [2:0]  rDadrs;
    logic        flag;
    logic        imm_sel;
    logic [7:0]  imm;
    logic [2:0]  rAadrs;
    logic [2:0]  rBadrs;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instruct;
    logic [2:0]  level;
    logic [3:0]  issued;

    int total = 0;
    int bad   = 0;

    instruction_encoder #(.DEPTH(4), .AW(2), .CNT_W(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .rDadrs       (rDadrs),
        .flag         (flag),
        .imm_sel      (imm_sel),
        .imm          (imm),
        .rAadrs       (rAadrs),
        .rBadrs       (rBadrs),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instruct (out_instruct),
        .level        (level),
        .issued       (issued)
    );

    always #5 clock = ~clock;

    // Advance one rising edge, then settle before driving or sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [3:0] op, input logic [2:0] rd,
                                 input logic fl, input logic sel, input logic [7:0] im,
                                 input logic [2:0] ra, input logic [2:0] rb);
        in_valid = iv;
        opcode   = op;
        rDadrs   = rd;
        flag     = fl;
        imm_sel  = sel;
        imm      = im;
        rAadrs   = ra;
        rBadrs   = rb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_instruct", 32'(out_instruct), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_issued", 32'(issued), 32'd0);

        $display("[TB] immediate form");
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'h3, 3'd5, 1'b1, 1'b1, 8'hA7, 3'bxxx, 3'bxxx);
        step();
        applyStimulus(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
        checkOutput("imm_out_valid", 32'(out_valid), 32'd1);
        checkOutput("imm_out_instruct", 32'(out_instruct), 32'h3BA7);
        checkOutput("imm_level", 32'(level), 32'd1);
        step();
        checkOutput("imm_issued", 32'(issued), 32'd1);
        checkOutput("imm_level_after_pop", 32'(level), 32'd0);

        $display("[TB] register form");
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'h1, 3'd2, 1'b0, 1'b0, 8'hFF, 3'd3, 3'd6);
        step();
        applyStimulus(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
        checkOutput("reg_out_instruct", 32'(out_instruct), 32'h1478);
        out_ready = 1'b1;
        step();
        checkOutput("reg_issued", 32'(issued), 32'd2);
        checkOutput("reg_out_valid_after_pop", 32'(out_valid), 32'd0);

        $display("[TB] fill and backpressure");
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 4'h0, 3'd0, 1'b0, 1'b1, 8'(i), 3'd0, 3'd0);
            checkOutput($sformatf("fill_in_ready_%0d", i), 32'(in_ready), (i <= 4) ? 32'd1 : 32'd0);
            step();
        end
        applyStimulus(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
        checkOutput("fill_level", 32'(level), 32'd4);
        checkOutput("fill_head", 32'(out_instruct), 32'h0001);
        step();
        checkOutput("stall_head", 32'(out_instruct), 32'h0001);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("drain_word_%0d", k), 32'(out_instruct), 32'(k));
            step();
        end
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
        checkOutput("drain_issued", 32'(issued), 32'd6);

        $display("[TB] simultaneous push and pop");
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4'h0, 3'd0, 1'b0, 1'b1, 8'(8'h10 + i), 3'd0, 3'd0);
            step();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b1, 4'h0, 3'd0, 1'b0, 1'b1, 8'(8'h12 + j), 3'd0, 3'd0);
            checkOutput($sformatf("pp_head_%0d", j), 32'(out_instruct), 32'(8'h10 + j));
            step();
            checkOutput($sformatf("pp_level_%0d", j), 32'(level), 32'd2);
        end
        applyStimulus(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
        checkOutput("wrap_issued_16", 32'(issued), 32'd0);
        checkOutput("pp_head_after", 32'(out_instruct), 32'h001A);
        step();
        checkOutput("wrap_issued_17", 32'(issued), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4'h0, 3'd0, 1'b0, 1'b1, 8'(8'h20 + i), 3'd0, 3'd0);
            step();
        end
        checkOutput("pre_reset_level", 32'(level), 32'd3);

        $display("[TB] reset mid-operation");
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'h0, 3'd0, 1'b0, 1'b1, 8'h55, 3'd0, 3'd0);
        reset_n = 1'b0;
        step();
        reset_n   = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
        checkOutput("mid_rst_level", 32'(level), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_out_instruct", 32'(out_instruct), 32'h0);
        checkOutput("mid_rst_issued", 32'(issued), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("mid_rst_no_ghost", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
